drive_mode_ctrl: RTL and testbench

- Parametrised top-level mode controller for the tracking robot. Takes decoded IR-remote commands and camera tracking results, and produces the mode, camera sub-state, drive command and speed, and a sub-block reset pulse.
- Extends the original mode FSM with:
  - configurable command codes,
  - a debounced target detect,
  - a LOST grace state,
  - timed IR manual driving,
  - a generic speed field.
- Sits between the IR decoder / camera pipeline and the motor PWM block.

---
 rtl/drive_mode_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_drive_mode_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drive_mode_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : drive_mode_ctrl                                            |
// | Description : Top-level mode controller for the tracking robot. Turns    |
// |               decoded IR-remote strobes and camera tracking results into |
// |               a mode, a camera sub-state, a drive command with speed and |
// |               a retriggerable sub-block reset pulse.                     |
// |                                                                          |
// | Ports       : clk_50          - 50 MHz system clock                      |
// |               reset_n         - asynchronous active-low reset            |
// |               ir_valid        - one-cycle strobe qualifying ir_code      |
// |               ir_code[7:0]    - decoded IR button code                   |
// |               cam_dir[2:0]    - 001 left, 010 right, 011 centre          |
// |               cam_speed       - camera-requested speed                   |
// |               target_detected - colour target present (synchronous)      |
// |               mode[1:0]       - IDLE=00, CAM=01, IR=10                   |
// |               cam_state[1:0]  - SEARCH=00, FOLLOW=01, LOST=10, PAUSE=11  |
// |               drive_state[1:0]- STOP=00, LEFT=01, RIGHT=10, FWD=11       |
// |               drive_speed     - speed applied with drive_state           |
// |               sub_reset       - high pulse on any mode/cam_state change  |
// |               HEX7..HEX0      - active-low seven-segment digits          |
// |                                                                          |
// | Option      : HEX_STATUS_EN - when defined, HEX7/HEX6 show the mode,     |
// |               HEX4 the camera state and HEX3..HEX0 the drive command.    |
// |               When undefined every HEX output is tied to 7'h7F.          |
// |                                                                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module drive_mode_ctrl #(
    parameter int         SPEED_W        = 2,
    parameter int         MAX_SPEED      = 2,
    parameter int         SEARCH_SPEED   = 1,
    parameter int         DET_CYCLES     = 4,
    parameter int         LOST_CYCLES    = 1000,
    parameter int         IR_HOLD_CYCLES = 5000,
    parameter int         RST_PULSE      = 3,
    parameter logic [7:0] CODE_CAM       = 8'h0F,
    parameter logic [7:0] CODE_IR        = 8'h13,
    parameter logic [7:0] CODE_IDLE      = 8'h10,
    parameter logic [7:0] CODE_FWD       = 8'h18,
    parameter logic [7:0] CODE_LEFT      = 8'h08,
    parameter logic [7:0] CODE_RIGHT     = 8'h5A,
    parameter logic [7:0] CODE_STOP      = 8'h1C
) (
    input  logic               clk_50,
    input  logic               reset_n,
    input  logic               ir_valid,
    input  logic [7:0]         ir_code,
    input  logic [2:0]         cam_dir,
    input  logic [SPEED_W-1:0] cam_speed,
    input  logic               target_detected,
    output logic [1:0]         mode,
    output logic [1:0]         cam_state,
    output logic [1:0]         drive_state,
    output logic [SPEED_W-1:0] drive_speed,
    output logic               sub_reset,
    output logic [6:0]         HEX7,
    output logic [6:0]         HEX6,
    output logic [6:0]         HEX5,
    output logic [6:0]         HEX4,
    output logic [6:0]         HEX3,
    output logic [6:0]         HEX2,
    output logic [6:0]         HEX1,
    output logic [6:0]         HEX0
);

    // State encodings
    localparam logic [1:0] c_MODE_IDLE = 2'b00;
    localparam logic [1:0] c_MODE_CAM  = 2'b01;
    localparam logic [1:0] c_MODE_IR   = 2'b10;

    localparam logic [1:0] c_CAM_SEARCH = 2'b00;
    localparam logic [1:0] c_CAM_FOLLOW = 2'b01;
    localparam logic [1:0] c_CAM_LOST   = 2'b10;
    localparam logic [1:0] c_CAM_PAUSE  = 2'b11;

    localparam logic [1:0] c_DRV_STOP  = 2'b00;
    localparam logic [1:0] c_DRV_LEFT  = 2'b01;
    localparam logic [1:0] c_DRV_RIGHT = 2'b10;
    localparam logic [1:0] c_DRV_FWD   = 2'b11;

    // Counter widths and load values
    localparam int c_DET_W   = $clog2(DET_CYCLES + 1);
    localparam int c_LOST_W  = $clog2(LOST_CYCLES + 1);
    localparam int c_HOLD_W  = $clog2(IR_HOLD_CYCLES + 1);
    localparam int c_PULSE_W = $clog2(RST_PULSE + 1);

    localparam logic [31:0]          c_DET_LIM    = 32'(DET_CYCLES);
    localparam logic [31:0]          c_LOST_LIM   = 32'(LOST_CYCLES - 1);
    localparam logic [SPEED_W-1:0]   c_MAX_SPD    = SPEED_W'(MAX_SPEED);
    localparam logic [SPEED_W-1:0]   c_SRCH_SPD   = SPEED_W'(SEARCH_SPEED);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_LOAD  = c_HOLD_W'(IR_HOLD_CYCLES);
    localparam logic [c_PULSE_W-1:0] c_PULSE_LOAD = c_PULSE_W'(RST_PULSE);

    // Registered state
    logic [1:0]           r_mode;
    logic [1:0]           r_cam_state;
    logic [1:0]           r_drive_state;
    logic [SPEED_W-1:0]   r_drive_speed;
    logic                 r_sub_reset;
    logic [c_DET_W-1:0]   r_det_cnt;
    logic [c_LOST_W-1:0]  r_lost_cnt;
    logic [c_HOLD_W-1:0]  r_hold_cnt;
    logic [c_PULSE_W-1:0] r_pulse_cnt;

    // Next-state values
    logic [1:0]           w_mode_nxt;
    logic                 w_mode_chg;
    logic [1:0]           w_cam_nxt;
    logic [c_DET_W-1:0]   w_det_nxt;
    logic [c_LOST_W-1:0]  w_lost_nxt;
    logic [1:0]           w_drv_nxt;
    logic [SPEED_W-1:0]   w_spd_nxt;
    logic [c_HOLD_W-1:0]  w_hold_nxt;
    logic [c_PULSE_W-1:0] w_pulse_nxt;
    logic [SPEED_W-1:0]   w_spd_sat;
    logic                 w_ir_stop;
    logic                 w_ir_move;

    // Mode selection: only recognised mode codes move the FSM.
    always_comb begin
        w_mode_nxt = r_mode;
        if (ir_valid) begin
            if (ir_code == CODE_CAM) begin
                w_mode_nxt = c_MODE_CAM;
            end else if (ir_code == CODE_IR) begin
                w_mode_nxt = c_MODE_IR;
            end else if (ir_code == CODE_IDLE) begin
                w_mode_nxt = c_MODE_IDLE;
            end
        end
    end

    assign w_mode_chg = (w_mode_nxt != r_mode);

    // Camera sub-FSM. A mode change always wins over a camera transition.
    always_comb begin
        w_cam_nxt  = r_cam_state;
        w_det_nxt  = r_det_cnt;
        w_lost_nxt = r_lost_cnt;
        if (w_mode_nxt != c_MODE_CAM) begin
            w_cam_nxt  = c_CAM_PAUSE;
            w_det_nxt  = '0;
            w_lost_nxt = '0;
        end else if (w_mode_chg) begin
            w_cam_nxt  = c_CAM_SEARCH;
            w_det_nxt  = '0;
            w_lost_nxt = '0;
        end else begin
            case (r_cam_state)
                c_CAM_SEARCH: begin
                    if (target_detected) begin
                        // Enter FOLLOW on the edge the run length would hit the limit
                        if ((32'(r_det_cnt) + 32'd1) >= c_DET_LIM) begin
                            w_cam_nxt = c_CAM_FOLLOW;
                            w_det_nxt = '0;
                        end else begin
                            w_det_nxt = r_det_cnt + 1'b1;
                        end
                    end else begin
                        w_det_nxt = '0;
                    end
                end
                c_CAM_FOLLOW: begin
                    if (!target_detected) begin
                        w_cam_nxt  = c_CAM_LOST;
                        w_lost_nxt = '0;
                    end
                end
                c_CAM_LOST: begin
                    if (target_detected) begin
                        w_cam_nxt  = c_CAM_FOLLOW;
                        w_lost_nxt = '0;
                    end else if ((32'(r_lost_cnt) + 32'd1) >= c_LOST_LIM) begin
                        w_cam_nxt  = c_CAM_SEARCH;
                        w_lost_nxt = '0;
                    end else begin
                        w_lost_nxt = r_lost_cnt + 1'b1;
                    end
                end
                default: begin
                    // PAUSE while in CAM is unreachable; recover into SEARCH
                    w_cam_nxt  = c_CAM_SEARCH;
                    w_det_nxt  = '0;
                    w_lost_nxt = '0;
                end
            endcase
        end
    end

    assign w_spd_sat = (cam_speed > c_MAX_SPD) ? c_MAX_SPD : cam_speed;
    assign w_ir_stop = ir_valid && (ir_code == CODE_STOP);
    assign w_ir_move = ir_valid && ((ir_code == CODE_FWD) || (ir_code == CODE_LEFT) ||
                                    (ir_code == CODE_RIGHT));

    // Drive command, derived from the next mode and camera state.
    always_comb begin
        w_drv_nxt  = r_drive_state;
        w_spd_nxt  = r_drive_speed;
        w_hold_nxt = '0;
        case (w_mode_nxt)
            c_MODE_CAM: begin
                case (w_cam_nxt)
                    c_CAM_SEARCH: begin
                        w_drv_nxt = c_DRV_RIGHT;
                        w_spd_nxt = c_SRCH_SPD;
                    end
                    c_CAM_FOLLOW: begin
                        case (cam_dir)
                            3'b001: begin
                                w_drv_nxt = c_DRV_LEFT;
                                w_spd_nxt = w_spd_sat;
                            end
                            3'b010: begin
                                w_drv_nxt = c_DRV_RIGHT;
                                w_spd_nxt = w_spd_sat;
                            end
                            3'b011: begin
                                w_drv_nxt = c_DRV_FWD;
                                w_spd_nxt = w_spd_sat;
                            end
                            default: begin
                                w_drv_nxt = c_DRV_STOP;
                                w_spd_nxt = '0;
                            end
                        endcase
                    end
                    c_CAM_LOST: begin
                        // Coast on the last FOLLOW command during the grace period
                        w_drv_nxt = r_drive_state;
                        w_spd_nxt = r_drive_speed;
                    end
                    default: begin
                        w_drv_nxt = c_DRV_STOP;
                        w_spd_nxt = '0;
                    end
                endcase
            end
            c_MODE_IR: begin
                if (w_mode_chg || w_ir_stop) begin
                    w_drv_nxt  = c_DRV_STOP;
                    w_spd_nxt  = '0;
                    w_hold_nxt = '0;
                end else if (w_ir_move) begin
                    if (ir_code == CODE_FWD) begin
                        w_drv_nxt = c_DRV_FWD;
                    end else if (ir_code == CODE_LEFT) begin
                        w_drv_nxt = c_DRV_LEFT;
                    end else begin
                        w_drv_nxt = c_DRV_RIGHT;
                    end
                    w_spd_nxt  = c_MAX_SPD;
                    w_hold_nxt = c_HOLD_LOAD;
                end else if (r_hold_cnt != '0) begin
                    w_hold_nxt = r_hold_cnt - 1'b1;
                    if (r_hold_cnt == c_HOLD_W'(1)) begin
                        w_drv_nxt = c_DRV_STOP;
                        w_spd_nxt = '0;
                    end
                end else begin
                    w_drv_nxt = c_DRV_STOP;
                    w_spd_nxt = '0;
                end
            end
            default: begin
                w_drv_nxt = c_DRV_STOP;
                w_spd_nxt = '0;
            end
        endcase
    end

    // Retriggerable pulse: any state change reloads the full width.
    always_comb begin
        w_pulse_nxt = r_pulse_cnt;
        if (w_mode_chg || (w_cam_nxt != r_cam_state)) begin
            w_pulse_nxt = c_PULSE_LOAD;
        end else if (r_pulse_cnt != '0) begin
            w_pulse_nxt = r_pulse_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_mode        <= c_MODE_IDLE;
            r_cam_state   <= c_CAM_PAUSE;
            r_drive_state <= c_DRV_STOP;
            r_drive_speed <= '0;
            r_sub_reset   <= 1'b0;
            r_det_cnt     <= '0;
            r_lost_cnt    <= '0;
            r_hold_cnt    <= '0;
            r_pulse_cnt   <= '0;
        end else begin
            r_mode        <= w_mode_nxt;
            r_cam_state   <= w_cam_nxt;
            r_drive_state <= w_drv_nxt;
            r_drive_speed <= w_spd_nxt;
            r_sub_reset   <= (w_pulse_nxt != '0);
            r_det_cnt     <= w_det_nxt;
            r_lost_cnt    <= w_lost_nxt;
            r_hold_cnt    <= w_hold_nxt;
            r_pulse_cnt   <= w_pulse_nxt;
        end
    end

    assign mode        = r_mode;
    assign cam_state   = r_cam_state;
    assign drive_state = r_drive_state;
    assign drive_speed = r_drive_speed;
    assign sub_reset   = r_sub_reset;

`ifdef HEX_STATUS_EN
    // Active-low segment patterns, bit order gfedcba
    localparam logic [6:0] c_SEG_BLANK = 7'h7F;
    localparam logic [6:0] c_SEG_A     = 7'h08;
    localparam logic [6:0] c_SEG_C     = 7'h46;
    localparam logic [6:0] c_SEG_D     = 7'h21;
    localparam logic [6:0] c_SEG_E     = 7'h06;
    localparam logic [6:0] c_SEG_F     = 7'h0E;
    localparam logic [6:0] c_SEG_G     = 7'h42;
    localparam logic [6:0] c_SEG_H     = 7'h09;
    localparam logic [6:0] c_SEG_I     = 7'h79;
    localparam logic [6:0] c_SEG_L     = 7'h47;
    localparam logic [6:0] c_SEG_O     = 7'h40;
    localparam logic [6:0] c_SEG_P     = 7'h0C;
    localparam logic [6:0] c_SEG_R     = 7'h2F;
    localparam logic [6:0] c_SEG_S     = 7'h12;
    localparam logic [6:0] c_SEG_T     = 7'h07;

    function automatic logic [6:0] f_hex_digit(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    logic [3:0] w_spd_digit;
    logic [6:0] r_hex7, r_hex6, r_hex4, r_hex3, r_hex2, r_hex1, r_hex0;

    assign w_spd_digit = 4'(r_drive_speed);

    // Displays trail the state registers by one cycle
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_hex7 <= c_SEG_BLANK;
            r_hex6 <= c_SEG_BLANK;
            r_hex4 <= c_SEG_BLANK;
            r_hex3 <= c_SEG_BLANK;
            r_hex2 <= c_SEG_BLANK;
            r_hex1 <= c_SEG_BLANK;
            r_hex0 <= c_SEG_BLANK;
        end else begin
            case (r_mode)
                c_MODE_IDLE: begin r_hex7 <= c_SEG_I;     r_hex6 <= c_SEG_D;     end
                c_MODE_CAM:  begin r_hex7 <= c_SEG_C;     r_hex6 <= c_SEG_A;     end
                c_MODE_IR:   begin r_hex7 <= c_SEG_I;     r_hex6 <= c_SEG_R;     end
                default:     begin r_hex7 <= c_SEG_BLANK; r_hex6 <= c_SEG_BLANK; end
            endcase
            case (r_cam_state)
                c_CAM_SEARCH: r_hex4 <= c_SEG_S;
                c_CAM_FOLLOW: r_hex4 <= c_SEG_F;
                c_CAM_LOST:   r_hex4 <= c_SEG_L;
                default:      r_hex4 <= c_SEG_P;
            endcase
            case (r_drive_state)
                c_DRV_STOP: begin
                    r_hex3 <= c_SEG_S; r_hex2 <= c_SEG_T; r_hex1 <= c_SEG_O; r_hex0 <= c_SEG_P;
                end
                c_DRV_LEFT: begin
                    r_hex3 <= c_SEG_L; r_hex2 <= c_SEG_E; r_hex1 <= c_SEG_F; r_hex0 <= c_SEG_T;
                end
                c_DRV_RIGHT: begin
                    r_hex3 <= c_SEG_R; r_hex2 <= c_SEG_G; r_hex1 <= c_SEG_H; r_hex0 <= c_SEG_T;
                end
                default: begin
                    r_hex3 <= c_SEG_F; r_hex2 <= c_SEG_BLANK; r_hex1 <= c_SEG_BLANK;
                    r_hex0 <= f_hex_digit(w_spd_digit);
                end
            endcase
        end
    end

    assign HEX7 = r_hex7;
    assign HEX6 = r_hex6;
    assign HEX5 = c_SEG_BLANK;
    assign HEX4 = r_hex4;
    assign HEX3 = r_hex3;
    assign HEX2 = r_hex2;
    assign HEX1 = r_hex1;
    assign HEX0 = r_hex0;
`else
    assign HEX7 = 7'h7F;
    assign HEX6 = 7'h7F;
    assign HEX5 = 7'h7F;
    assign HEX4 = 7'h7F;
    assign HEX3 = 7'h7F;
    assign HEX2 = 7'h7F;
    assign HEX1 = 7'h7F;
    assign HEX0 = 7'h7F;
`endif

endmodule
`default_nettype wire

// File: tb/tb_drive_mode_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_drive_mode_ctrl                                         |
// | Description : Self-checking bench for drive_mode_ctrl: a vector table,   |
// |               directed multi-cycle sequences and random stimulus, all    |
// |               compared against a timestamp-based reference model.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_drive_mode_ctrl;

    localparam int DET   = 4;
    localparam int LOST  = 1000;
    localparam int HOLD  = 5000;
    localparam int PULSE = 3;
    localparam int MAXS  = 2;
    localparam int SRCH  = 1;

    logic       clk_50 = 1'b0;
    logic       reset_n;
    logic       ir_valid;
    logic [7:0] ir_code;
    logic [2:0] cam_dir;
    logic [1:0] cam_speed;
    logic       target_detected;
    logic [1:0] mode, cam_state, drive_state, drive_speed;
    logic       sub_reset;
    logic [6:0] HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;

    always #10 clk_50 = ~clk_50;

    drive_mode_ctrl dut (
        .clk_50          (clk_50),
        .reset_n         (reset_n),
        .ir_valid        (ir_valid),
        .ir_code         (ir_code),
        .cam_dir         (cam_dir),
        .cam_speed       (cam_speed),
        .target_detected (target_detected),
        .mode            (mode),
        .cam_state       (cam_state),
        .drive_state     (drive_state),
        .drive_speed     (drive_speed),
        .sub_reset       (sub_reset),
        .HEX7            (HEX7),
        .HEX6            (HEX6),
        .HEX5            (HEX5),
        .HEX4            (HEX4),
        .HEX3            (HEX3),
        .HEX2            (HEX2),
        .HEX1            (HEX1),
        .HEX0            (HEX0)
    );

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // Modes: 0 idle, 1 cam, 2 ir. Camera: 0 search, 1 follow, 2 lost, 3 pause.
    // Drive: 0 stop, 1 left, 2 right, 3 fwd. Timers are kept as absolute
    // cycle stamps rather than down/up counters.
    int cyc = 0;
    int m_mode, m_cam, m_drv, m_spd;
    int m_run;        // consecutive detect cycles seen in SEARCH
    int m_lost_t0;    // cycle at which LOST was entered
    int m_hold_until; // IR command expires at this cycle
    int m_last_chg;   // cycle of last mode/camera change

    function automatic void model_reset();
        m_mode = 0; m_cam = 3; m_drv = 0; m_spd = 0;
        m_run = 0; m_lost_t0 = 0; m_hold_until = 0; m_last_chg = -100;
    endfunction

    function automatic void model_edge();
        int nm, nc;
        cyc++;
        nm = m_mode;
        if (ir_valid) begin
            if (ir_code == 8'h0F)      nm = 1;
            else if (ir_code == 8'h13) nm = 2;
            else if (ir_code == 8'h10) nm = 0;
        end
        nc = m_cam;
        if (nm != 1) begin
            nc = 3;
        end else if (nm != m_mode) begin
            nc = 0;
            m_run = 0;
        end else begin
            case (m_cam)
                0: begin
                    m_run = target_detected ? m_run + 1 : 0;
                    if (m_run >= DET) begin nc = 1; m_run = 0; end
                end
                1: if (!target_detected) begin nc = 2; m_lost_t0 = cyc; end
                2: begin
                    if (target_detected) nc = 1;
                    else if (cyc - m_lost_t0 >= LOST - 1) nc = 0;
                end
                default: nc = 0;
            endcase
        end
        if (nm == 0) begin
            m_drv = 0; m_spd = 0;
        end else if (nm == 1) begin
            if (nc == 0) begin
                m_drv = 2; m_spd = SRCH;
            end else if (nc == 1) begin
                if (cam_dir >= 3'd1 && cam_dir <= 3'd3) begin
                    m_drv = int'(cam_dir);
                    m_spd = (int'(cam_speed) > MAXS) ? MAXS : int'(cam_speed);
                end else begin
                    m_drv = 0; m_spd = 0;
                end
            end
        end else begin
            if (nm != m_mode || (ir_valid && ir_code == 8'h1C)) begin
                m_drv = 0; m_spd = 0; m_hold_until = 0;
            end else if (ir_valid && (ir_code == 8'h18 || ir_code == 8'h08 || ir_code == 8'h5A)) begin
                m_drv = (ir_code == 8'h18) ? 3 : (ir_code == 8'h08) ? 1 : 2;
                m_spd = MAXS;
                m_hold_until = cyc + HOLD;
            end else if (cyc >= m_hold_until) begin
                m_drv = 0; m_spd = 0;
            end
        end
        if (nm != m_mode || nc != m_cam) m_last_chg = cyc;
        m_mode = nm;
        m_cam  = nc;
    endfunction

    task automatic check_model();
        chk("model_mode", mode, m_mode);
        chk("model_cam_state", cam_state, m_cam);
        chk("model_drive_state", drive_state, m_drv);
        chk("model_drive_speed", drive_speed, m_spd);
        chk("model_sub_reset", sub_reset, ((cyc - m_last_chg) < PULSE) ? 1 : 0);
    endtask

    // One clock: DUT and model advance on the rising edge, compare on the falling edge.
    task automatic step();
        @(posedge clk_50);
        model_edge();
        @(negedge clk_50);
        check_model();
    endtask

    task automatic set_in(input logic v, input logic [7:0] c, input logic t,
                          input logic [2:0] d, input logic [1:0] s);
        ir_valid = v; ir_code = c; target_detected = t; cam_dir = d; cam_speed = s;
    endtask

    task automatic chk_hex();
        chk("hex7", HEX7, 7'h7F); chk("hex6", HEX6, 7'h7F);
        chk("hex5", HEX5, 7'h7F); chk("hex4", HEX4, 7'h7F);
        chk("hex3", HEX3, 7'h7F); chk("hex2", HEX2, 7'h7F);
        chk("hex1", HEX1, 7'h7F); chk("hex0", HEX0, 7'h7F);
    endtask

    typedef struct {
        logic       v;
        logic [7:0] code;
        logic       td;
        logic [2:0] dir;
        logic [1:0] spd;
        logic [1:0] e_mode;
        logic [1:0] e_cam;
        logic [1:0] e_drv;
        logic [1:0] e_spd;
        logic       e_sub;
    } vec_t;

    vec_t tbl [29];

    function automatic logic [7:0] pick_code(input int k);
        case (k)
            0: return 8'h0F;
            1: return 8'h13;
            2: return 8'h10;
            3: return 8'h18;
            4: return 8'h08;
            5: return 8'h5A;
            6: return 8'h1C;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           v  code   td dir spd   mode cam drv spd sub
        tbl[0]  = '{1, 8'h0F, 0, 0, 0,    1,   0,  2,  1,  1};
        tbl[1]  = '{0, 8'h00, 1, 0, 0,    1,   0,  2,  1,  1};
        tbl[2]  = '{0, 8'h00, 1, 0, 0,    1,   0,  2,  1,  1};
        tbl[3]  = '{0, 8'h00, 1, 0, 0,    1,   0,  2,  1,  0};
        tbl[4]  = '{0, 8'h00, 0, 0, 0,    1,   0,  2,  1,  0};
        tbl[5]  = '{0, 8'h00, 1, 3, 3,    1,   0,  2,  1,  0};
        tbl[6]  = '{0, 8'h00, 1, 3, 3,    1,   0,  2,  1,  0};
        tbl[7]  = '{0, 8'h00, 1, 3, 3,    1,   0,  2,  1,  0};
        tbl[8]  = '{0, 8'h00, 1, 3, 3,    1,   1,  3,  2,  1};
        tbl[9]  = '{0, 8'h00, 1, 1, 1,    1,   1,  1,  1,  1};
        tbl[10] = '{0, 8'h00, 1, 2, 2,    1,   1,  2,  2,  1};
        tbl[11] = '{0, 8'h00, 1, 0, 3,    1,   1,  0,  0,  0};
        tbl[12] = '{0, 8'h00, 1, 3, 0,    1,   1,  3,  0,  0};
        tbl[13] = '{0, 8'h00, 1, 7, 3,    1,   1,  0,  0,  0};
        tbl[14] = '{0, 8'h00, 1, 3, 1,    1,   1,  3,  1,  0};
        tbl[15] = '{0, 8'h00, 0, 1, 3,    1,   2,  3,  1,  1};
        tbl[16] = '{0, 8'h00, 1, 2, 3,    1,   1,  2,  2,  1};
        tbl[17] = '{1, 8'h0F, 1, 2, 2,    1,   1,  2,  2,  1};
        tbl[18] = '{1, 8'h55, 1, 2, 1,    1,   1,  2,  1,  1};
        tbl[19] = '{0, 8'h00, 1, 2, 1,    1,   1,  2,  1,  0};
        tbl[20] = '{1, 8'h13, 0, 0, 0,    2,   3,  0,  0,  1};
        tbl[21] = '{1, 8'h08, 0, 0, 0,    2,   3,  1,  2,  1};
        tbl[22] = '{0, 8'h00, 0, 0, 0,    2,   3,  1,  2,  1};
        tbl[23] = '{1, 8'h5A, 0, 0, 0,    2,   3,  2,  2,  0};
        tbl[24] = '{1, 8'h1C, 0, 0, 0,    2,   3,  0,  0,  0};
        tbl[25] = '{1, 8'h18, 0, 0, 0,    2,   3,  3,  2,  0};
        tbl[26] = '{1, 8'h13, 0, 0, 0,    2,   3,  3,  2,  0};
        tbl[27] = '{1, 8'h10, 0, 0, 0,    0,   3,  0,  0,  1};
        tbl[28] = '{1, 8'h18, 0, 0, 0,    0,   3,  0,  0,  1};

        reset_n = 1'b0;
        set_in(0, 8'h00, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk_50);
        chk("rst_mode", mode, 0);
        chk("rst_cam_state", cam_state, 3);
        chk("rst_drive_state", drive_state, 0);
        chk("rst_drive_speed", drive_speed, 0);
        chk("rst_sub_reset", sub_reset, 0);
        chk_hex();
        reset_n = 1'b1;

        // Vector table
        for (int i = 0; i < 29; i++) begin
            set_in(tbl[i].v, tbl[i].code, tbl[i].td, tbl[i].dir, tbl[i].spd);
            step();
            chk($sformatf("tbl%0d_mode", i), mode, tbl[i].e_mode);
            chk($sformatf("tbl%0d_cam", i), cam_state, tbl[i].e_cam);
            chk($sformatf("tbl%0d_drv", i), drive_state, tbl[i].e_drv);
            chk($sformatf("tbl%0d_spd", i), drive_speed, tbl[i].e_spd);
            chk($sformatf("tbl%0d_sub", i), sub_reset, tbl[i].e_sub);
        end

        // IDLE selected on the same edge the detect threshold is reached
        set_in(1, 8'h0F, 0, 3, 3);
        step();
        set_in(0, 8'h00, 1, 3, 3);
        repeat (3) step();
        chk("thr_pre_cam", cam_state, 0);
        set_in(1, 8'h10, 1, 3, 3);
        step();
        chk("thr_mode", mode, 0);
        chk("thr_cam", cam_state, 3);
        chk("thr_drv", drive_state, 0);
        chk("thr_spd", drive_speed, 0);
        set_in(0, 8'h00, 1, 3, 3);
        step();
        chk("thr_after_cam", cam_state, 3);

        // LOST grace period: 999 low cycles stay LOST, 1000 fall back to SEARCH
        set_in(1, 8'h0F, 0, 3, 3);
        step();
        set_in(0, 8'h00, 1, 3, 3);
        repeat (3) step();
        chk("fol_pre_cam", cam_state, 0);
        step();
        chk("fol_cam", cam_state, 1);
        chk("fol_drv", drive_state, 3);
        chk("fol_spd", drive_speed, 2);
        target_detected = 1'b0;
        repeat (999) step();
        chk("lost999_cam", cam_state, 2);
        chk("lost999_drv", drive_state, 3);
        chk("lost999_spd", drive_speed, 2);
        target_detected = 1'b1;
        step();
        chk("refollow_cam", cam_state, 1);
        target_detected = 1'b0;
        repeat (999) step();
        chk("lost_b_cam", cam_state, 2);
        step();
        chk("lost_to_search_cam", cam_state, 0);
        chk("lost_to_search_sub", sub_reset, 1);
        chk("lost_to_search_drv", drive_state, 2);
        chk("lost_to_search_spd", drive_speed, 1);

        // IR timed driving
        set_in(1, 8'h13, 0, 0, 0);
        step();
        chk("ir_mode", mode, 2);
        chk("ir_entry_drv", drive_state, 0);
        set_in(1, 8'h08, 0, 0, 0);
        step();
        chk("ir_left_drv", drive_state, 1);
        chk("ir_left_spd", drive_speed, 2);
        ir_valid = 1'b0;
        repeat (4999) step();
        chk("ir_hold_end_drv", drive_state, 1);
        step();
        chk("ir_expire_drv", drive_state, 0);
        chk("ir_expire_spd", drive_speed, 0);
        set_in(1, 8'h08, 0, 0, 0);
        step();
        ir_valid = 1'b0;
        repeat (100) step();
        set_in(1, 8'h18, 0, 0, 0);
        step();
        chk("ir_fwd_drv", drive_state, 3);
        ir_valid = 1'b0;
        repeat (4999) step();
        chk("ir_reload_drv", drive_state, 3);
        chk("ir_reload_spd", drive_speed, 2);
        step();
        chk("ir_reload_expire", drive_state, 0);
        set_in(1, 8'h5A, 0, 0, 0);
        step();
        chk("ir_right_drv", drive_state, 2);
        ir_valid = 1'b0;
        repeat (10) step();
        set_in(1, 8'h1C, 0, 0, 0);
        step();
        chk("ir_stop_drv", drive_state, 0);
        chk("ir_stop_spd", drive_speed, 0);

        // Asynchronous reset during an active hold and pulse
        set_in(1, 8'h10, 0, 0, 0);
        step();
        set_in(1, 8'h13, 0, 0, 0);
        step();
        set_in(1, 8'h08, 0, 0, 0);
        step();
        chk("pre_rst_drv", drive_state, 1);
        chk("pre_rst_sub", sub_reset, 1);
        ir_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("arst_mode", mode, 0);
        chk("arst_cam", cam_state, 3);
        chk("arst_drv", drive_state, 0);
        chk("arst_spd", drive_speed, 0);
        chk("arst_sub", sub_reset, 0);
        @(posedge clk_50);
        @(negedge clk_50);
        chk("arst_hold_mode", mode, 0);
        reset_n = 1'b1;
        set_in(1, 8'h13, 0, 0, 0);
        step();
        chk("ir_again_sub", sub_reset, 1);
        ir_valid = 1'b0;
        repeat (4) step();
        chk("ir_pulse_done", sub_reset, 0);
        set_in(1, 8'h13, 0, 0, 0);
        step();
        chk("ir_reselect_sub", sub_reset, 0);
        chk("ir_reselect_mode", mode, 2);
        ir_valid = 1'b0;
        step();
        chk("ir_reselect_sub2", sub_reset, 0);

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) target_detected = ~target_detected;
            ir_valid  = ($urandom_range(0, 15) == 0);
            ir_code   = pick_code(int'($urandom_range(0, 7)));
            cam_dir   = 3'($urandom_range(0, 7));
            cam_speed = 2'($urandom_range(0, 3));
            step();
        end

        chk_hex();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
